axil_regif: RTL
===============

# axil_regif

Parametrised AXI4-Lite slave front-end that replaces the fixed three-register PS-to-PL bridge with a fully handshaked, byte-strobed, N-register interface. It sits between the PS general-purpose AXI port and a peripheral register bank such as the SPI control/status/data registers. AW and W are captured independently, B and R are held until accepted, and unmapped accesses are flagged. Registers are exposed as one-hot write/read strobes plus a flattened read bus.

## Interface
- `DATA_W`, 32: AXI data width, either 32 or 64; `STRB_W = DATA_W/8`, `ADDR_LSB = log2(STRB_W)`.
- `ADDR_W`, 16: decoded address bits; bits at `ADDR_W` and above are ignored.
- `NUM_REGS`, 4: register count, 1..256; `IDX_W = max(1, clog2(NUM_REGS))`.

- `FCLK_CLK0` in 1: sole clock.
- `RST_N` in 1: asynchronous active-low reset.
- `AXI_awaddr` in 32, `AXI_awprot` in 3 (ignored), `AXI_awvalid` in 1, `AXI_awready` out 1: write address channel.
- `AXI_wdata` in `DATA_W`, `AXI_wstrb` in `STRB_W`, `AXI_wvalid` in 1, `AXI_wready` out 1: write data channel.
- `AXI_bresp` out 2, `AXI_bvalid` out 1, `AXI_bready` in 1: write response channel.
- `AXI_araddr` in 32, `AXI_arprot` in 3 (ignored), `AXI_arvalid` in 1, `AXI_arready` out 1: read address channel.
- `AXI_rdata` out `DATA_W`, `AXI_rresp` out 2, `AXI_rvalid` out 1, `AXI_rready` in 1: read data channel.
- `o_wr_en` out `NUM_REGS`: one-hot, single-cycle write strobe.
- `o_wr_data` out `DATA_W`, `o_wr_strb` out `STRB_W`: write payload, valid while `o_wr_en` is nonzero.
- `o_rd_en` out `NUM_REGS`: one-hot, single-cycle read strobe, used for side effects such as FIFO pop or clear-on-read.
- `i_rd_data` in `NUM_REGS*DATA_W`: register i is `i_rd_data[i*DATA_W +: DATA_W]`.

## Operation
- Decode: `idx = addr[ADDR_LSB +: IDX_W]`. An access is mapped iff `addr[ADDR_W-1:ADDR_LSB] < NUM_REGS`. Byte-offset bits are ignored.
- Write path: two holding registers, `aw_full` (address) and `w_full` (data + strobe).
  - `AXI_awready = ~aw_full & ~AXI_bvalid`.
  - `AXI_wready = ~w_full & ~AXI_bvalid`.
- Commit condition: `(aw_full | aw_hs) & (w_full | w_hs)`. On that edge:
  - `o_wr_en[idx]` is set only if mapped, and it pulses for exactly one cycle.
  - `o_wr_data` and `o_wr_strb` are loaded.
  - `AXI_bvalid` is set; `AXI_bresp` becomes OKAY, or per Configuration.
  - Both full flags clear.
- `AXI_bvalid` holds, with `bresp` stable, until `AXI_bready`. It clears on the edge where `bvalid & bready`.
- `wstrb == 0` still pulses `o_wr_en`; the bank writes no bytes.
- Read path: `AXI_arready = ~AXI_rvalid`. On AR handshake:
  - `AXI_rdata` is loaded with the selected register (0 if unmapped).
  - `AXI_rvalid` is set.
  - `o_rd_en[idx]` pulses for one cycle, only if mapped.
- `AXI_rvalid`, `AXI_rdata` and `AXI_rresp` hold until `AXI_rready`.
- Read and write channels are fully independent. A write commit and a read handshake on the same edge to the same register: `rdata` is the pre-write value.
- Reset, asynchronous or mid-transaction: all holding flags, valids and strobes clear. In-flight transactions are dropped with no response.

## Timing
- Reset values:
  - `AXI_bvalid`, `AXI_rvalid`: 0.
  - `AXI_bresp`, `AXI_rresp`: 0.
  - `AXI_rdata`, `o_wr_data`, `o_wr_strb`: 0.
  - `o_wr_en`, `o_rd_en`: 0.
  - `AXI_awready`, `AXI_wready`, `AXI_arready`: 1 in the first cycle after `RST_N` deasserts; all three are gated low while `RST_N` is low.
- Write latency: `o_wr_en` and `AXI_bvalid` rise 1 cycle after the later of the AW/W handshakes.
- Write throughput: back-to-back writes with `bready` held high take 2 cycles each.
- Read latency: `AXI_rvalid` and `o_rd_en` rise 1 cycle after the AR handshake.
- Read throughput: 1 read per 2 cycles with `rready` held high.
- AW arriving N cycles before W (or W before AW) is held indefinitely. The already-captured channel's ready stays low until commit.
- No combinational path from any AXI input to any AXI output except through registered state.

## Configuration
- `AXIL_REGIF_SLVERR_EN` defined: unmapped writes return `bresp=2'b10` (SLVERR) and unmapped reads return `rresp=2'b10` with `rdata=0`. No strobe pulses in either case.
- `AXIL_REGIF_SLVERR_EN` undefined: unmapped accesses return OKAY (`2'b00`), reads return 0, and no strobe pulses. Writes are silently dropped.

## Test plan
- Simultaneous write: AW+W together, addr `0x08`, data `0xDEADBEEF`, strb `0xF`, `bready=1` → next cycle `o_wr_en=4'b0100` for 1 cycle, `o_wr_data=0xDEADBEEF`, `bvalid=1`, `bresp=0`; `bvalid` low the cycle after.
- Staggered write: W (data `0x5A`, strb `0x1`) 3 cycles before AW (addr `0x00`) → `wready` low after W capture; `o_wr_en=4'b0001` and `o_wr_strb=0x1` 1 cycle after the AW handshake. Repeat with AW before W.
- Backpressure: hold `bready=0` for 5 cycles after commit → `bvalid` and `bresp` stable, `awready=wready=0` throughout, a new AW is not accepted until 1 cycle after the B handshake.
- Read: `i_rd_data` reg1 `=0x12345678`, AR addr `0x04`, `rready=0` for 3 cycles → `rvalid=1` with `rdata=0x12345678` stable, `o_rd_en=4'b0010` for exactly one cycle, `arready=0` until the R handshake.
- Unmapped: read and write addr `0x10` with `NUM_REGS=4` → with `AXIL_REGIF_SLVERR_EN`: `resp=2'b10`, `rdata=0`, no strobes; without it: `resp=0`, `rdata=0`, no strobes.
- Reset mid-transaction: AW captured, `RST_N` pulled low before W → all outputs at reset values immediately; after release, a full write to `0x00` completes normally with no stale address.

Source files
------------

// File: rtl/axil_regif.sv
// AXI4-Lite slave front-end exposing NUM_REGS registers as one-hot write/read strobes.
// Define AXIL_REGIF_SLVERR_EN to answer unmapped accesses with SLVERR instead of OKAY.

module axil_regif #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int NUM_REGS = 4
) (
    input  logic                       FCLK_CLK0,
    input  logic                       RST_N,
    input  logic [31:0]                AXI_awaddr,
    input  logic [2:0]                 AXI_awprot,
    input  logic                       AXI_awvalid,
    output logic                       AXI_awready,
    input  logic [DATA_W-1:0]          AXI_wdata,
    input  logic [DATA_W/8-1:0]        AXI_wstrb,
    input  logic                       AXI_wvalid,
    output logic                       AXI_wready,
    output logic [1:0]                 AXI_bresp,
    output logic                       AXI_bvalid,
    input  logic                       AXI_bready,
    input  logic [31:0]                AXI_araddr,
    input  logic [2:0]                 AXI_arprot,
    input  logic                       AXI_arvalid,
    output logic                       AXI_arready,
    output logic [DATA_W-1:0]          AXI_rdata,
    output logic [1:0]                 AXI_rresp,
    output logic                       AXI_rvalid,
    input  logic                       AXI_rready,
    output logic [NUM_REGS-1:0]        o_wr_en,
    output logic [DATA_W-1:0]          o_wr_data,
    output logic [DATA_W/8-1:0]        o_wr_strb,
    output logic [NUM_REGS-1:0]        o_rd_en,
    input  logic [NUM_REGS*DATA_W-1:0] i_rd_data
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int OFF_W    = ADDR_W - ADDR_LSB;

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REGIF_SLVERR_EN
    localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
    localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

    function automatic logic is_mapped(input logic [OFF_W-1:0] word);
        return 33'(word) < 33'(NUM_REGS);
    endfunction

    function automatic logic [NUM_REGS-1:0] onehot(input logic [OFF_W-1:0] word);
        logic [NUM_REGS-1:0] v;
        v = '0;
        v[word[IDX_W-1:0]] = 1'b1;
        return v;
    endfunction

    // Write-side holding registers and outputs
    logic                aw_full_q, aw_full_d;
    logic [OFF_W-1:0]    aw_word_q, aw_word_d;
    logic                w_full_q, w_full_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic [STRB_W-1:0]   w_strb_q, w_strb_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [STRB_W-1:0]   wr_strb_q, wr_strb_d;

    // Read-side outputs
    logic                rvalid_q, rvalid_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NUM_REGS-1:0] rd_en_q, rd_en_d;

    logic                aw_hs, w_hs, ar_hs, wr_commit;
    logic [OFF_W-1:0]    aw_word_in, ar_word_in, cm_word;
    logic [DATA_W-1:0]   cm_data;
    logic [STRB_W-1:0]   cm_strb;
    logic [DATA_W-1:0]   reg_words [NUM_REGS];

    // Readies depend only on registered state; RST_N gates them low during reset.
    assign AXI_awready = RST_N & ~aw_full_q & ~bvalid_q;
    assign AXI_wready  = RST_N & ~w_full_q & ~bvalid_q;
    assign AXI_arready = RST_N & ~rvalid_q;

    assign aw_hs      = AXI_awvalid & AXI_awready;
    assign w_hs       = AXI_wvalid & AXI_wready;
    assign ar_hs      = AXI_arvalid & AXI_arready;
    assign wr_commit  = (aw_full_q | aw_hs) & (w_full_q | w_hs);

    assign aw_word_in = AXI_awaddr[ADDR_W-1:ADDR_LSB];
    assign ar_word_in = AXI_araddr[ADDR_W-1:ADDR_LSB];
    assign cm_word    = aw_full_q ? aw_word_q : aw_word_in;
    assign cm_data    = w_full_q ? w_data_q : AXI_wdata;
    assign cm_strb    = w_full_q ? w_strb_q : AXI_wstrb;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_words[i] = i_rd_data[i*DATA_W +: DATA_W];
        end
    end

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        aw_full_d = aw_full_q;
        aw_word_d = aw_word_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q & ~AXI_bready;
        bresp_d   = bresp_q;
        wr_en_d   = '0;
        wr_data_d = wr_data_q;
        wr_strb_d = wr_strb_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_word_d = aw_word_in;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = AXI_wdata;
            w_strb_d = AXI_wstrb;
        end
        if (wr_commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            wr_data_d = cm_data;
            wr_strb_d = cm_strb;
            if (is_mapped(cm_word)) begin
                wr_en_d = onehot(cm_word);
                bresp_d = RESP_OKAY;
            end else begin
                bresp_d = RESP_UNMAPPED;
            end
        end
    end

    always_comb begin
        rvalid_d = rvalid_q & ~AXI_rready;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        rd_en_d  = '0;

        if (ar_hs) begin
            rvalid_d = 1'b1;
            if (is_mapped(ar_word_in)) begin
                rdata_d = reg_words[ar_word_in[IDX_W-1:0]];
                rresp_d = RESP_OKAY;
                rd_en_d = onehot(ar_word_in);
            end else begin
                rdata_d = '0;
                rresp_d = RESP_UNMAPPED;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the payload holding registers are reset as well, keeping X off o_wr_data after reset.
    always_ff @(posedge FCLK_CLK0 or negedge RST_N) begin
        if (!RST_N) begin
            aw_full_q <= 1'b0;
            aw_word_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            wr_en_q   <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            rd_en_q   <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_word_q <= aw_word_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wr_strb_q <= wr_strb_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            rd_en_q   <= rd_en_d;
        end
    end

    assign AXI_bvalid = bvalid_q;
    assign AXI_bresp  = bresp_q;
    assign AXI_rvalid = rvalid_q;
    assign AXI_rresp  = rresp_q;
    assign AXI_rdata  = rdata_q;
    assign o_wr_en    = wr_en_q;
    assign o_wr_data  = wr_data_q;
    assign o_wr_strb  = wr_strb_q;
    assign o_rd_en    = rd_en_q;

    // Protection bits and address bits outside the decoded window carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{AXI_awprot, AXI_arprot, AXI_awaddr, AXI_araddr};

endmodule
